// File: rtl/rom_region_loader.sv
// Purpose : parses a ROM download byte stream (id, 24-bit BE length, payload)
//           into 16-bit little-endian write requests, a board config word and
//           a done/error status.
// Latency : a word request appears one cycle after the strobe of its odd byte
//           (or of the final byte of an odd-length chunk).
// Backpressure: ioctl_wait mirrors out_valid. A byte strobed while it is high
//           is lost and the loader stops in ERROR.
//
// Ports:
//   clk, reset_n                     clock, asynchronous active-low reset
//   ioctl_download/_wr/_dout/_wait   downloader byte stream and stall request
//   out_valid/out_ready              write request handshake
//   out_addr/out_data/out_be/out_storage   write request fields
//   board_cfg/cfg_valid              config word from the 8'h80 chunk
//   load_done/load_error             download status, held until the next download
//
// Build option: define LOADER_CHECKSUM_EN to expect one trailing byte after each
// payload and config chunk, equal to the 8-bit sum of that chunk's payload bytes.

package rom_region_loader_pkg;

    typedef enum logic [3:0] {
        STORAGE_SDR  = 4'd0,
        STORAGE_DDR  = 4'd1,
        STORAGE_BRAM = 4'd2
    } region_storage_t;

    typedef struct packed {
        logic [7:0] game;
        logic [7:0] unused;
    } board_cfg_t;

    typedef struct packed {
        logic [31:0]     base_addr;
        region_storage_t storage;
    } load_region_t;

    localparam logic [7:0] GAME_THUNDFOX = 8'h03;
    localparam logic [7:0] ID_CFG        = 8'h80;
    localparam logic [7:0] ID_END        = 8'hFF;

    // LOAD_REGIONS table: destination of each payload chunk id.
    function automatic load_region_t load_region(input logic [7:0] id);
        load_region_t r;
        case (id)
            8'd0:    r = '{base_addr: 32'h0000_0000, storage: STORAGE_SDR};
            8'd1:    r = '{base_addr: 32'h0090_0000, storage: STORAGE_SDR};
            8'd2:    r = '{base_addr: 32'h0000_0000, storage: STORAGE_DDR};
            8'd3:    r = '{base_addr: 32'h0020_0000, storage: STORAGE_DDR};
            8'd4:    r = '{base_addr: 32'h0000_0000, storage: STORAGE_BRAM};
            8'd5:    r = '{base_addr: 32'h0001_0000, storage: STORAGE_BRAM};
            default: r = '{base_addr: 32'h0000_0000, storage: STORAGE_SDR};
        endcase
        return r;
    endfunction

endpackage

module rom_region_loader
    import rom_region_loader_pkg::*;
#(
    parameter int unsigned NUM_REGIONS = 6,
    parameter logic [23:0] MAX_LEN     = 24'h80_0000
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic            ioctl_download,
    input  logic            ioctl_wr,
    input  logic [7:0]      ioctl_dout,
    output logic            ioctl_wait,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [31:0]     out_addr,
    output logic [15:0]     out_data,
    output logic [1:0]      out_be,
    output region_storage_t out_storage,
    output board_cfg_t      board_cfg,
    output logic            cfg_valid,
    output logic            load_done,
    output logic            load_error
);

    typedef enum logic [3:0] {
        IDLE,
        HDR_ID,
        HDR_LEN0,
        HDR_LEN1,
        HDR_LEN2,
        DATA,
        CFG,
`ifdef LOADER_CHECKSUM_EN
        CSUM,
`endif
        DONE,
        ERROR
    } state_t;

    // Where a chunk goes once its last payload byte (or empty header) is seen.
`ifdef LOADER_CHECKSUM_EN
    localparam state_t CHUNK_END = CSUM;
`else
    localparam state_t CHUNK_END = HDR_ID;
`endif

    state_t          state_q, state_d;
    logic            dl_q;
    logic            is_cfg_q, is_cfg_d;
    logic [23:0]     len_q, len_d;      // length bytes during header, then bytes remaining
    logic [23:0]     off_q, off_d;      // byte offset within the current chunk
    logic [7:0]      lo_q, lo_d;        // held even byte
    logic [31:0]     base_q, base_d;
    region_storage_t storage_q, storage_d;
    logic            out_valid_q, out_valid_d;
    logic [31:0]     out_addr_q, out_addr_d;
    logic [15:0]     out_data_q, out_data_d;
    logic [1:0]      out_be_q, out_be_d;
    region_storage_t out_storage_q, out_storage_d;
    board_cfg_t      board_cfg_q, board_cfg_d;
    logic            cfg_valid_q, cfg_valid_d;
    logic            load_done_q, load_done_d;
    logic            load_error_q, load_error_d;
`ifdef LOADER_CHECKSUM_EN
    logic [7:0]      csum_q, csum_d;
`endif

    logic            dl_rise;
    logic            dl_fall;
    load_region_t    region;
    logic [23:0]     len_full;
    logic [31:0]     word_addr;

    assign dl_rise   = ioctl_download & ~dl_q;
    assign dl_fall   = ~ioctl_download & dl_q;
    assign region    = load_region(ioctl_dout);
    assign len_full  = {len_q[23:8], ioctl_dout};
    // Both bytes of a word share the even offset's address.
    assign word_addr = base_q + {8'h00, off_q[23:1], 1'b0};

    always_comb begin
        state_d       = state_q;
        is_cfg_d      = is_cfg_q;
        len_d         = len_q;
        off_d         = off_q;
        lo_d          = lo_q;
        base_d        = base_q;
        storage_d     = storage_q;
        out_valid_d   = out_valid_q;
        out_addr_d    = out_addr_q;
        out_data_d    = out_data_q;
        out_be_d      = out_be_q;
        out_storage_d = out_storage_q;
        board_cfg_d   = board_cfg_q;
        cfg_valid_d   = cfg_valid_q;
        load_done_d   = load_done_q;
        load_error_d  = load_error_q;
`ifdef LOADER_CHECKSUM_EN
        csum_d        = csum_q;
`endif

        if (out_valid_q && out_ready) begin
            out_valid_d = 1'b0;
        end

        if (dl_rise) begin
            // A new download abandons whatever was in flight, including a pending word.
            state_d      = HDR_ID;
            out_valid_d  = 1'b0;
            board_cfg_d  = '0;
            cfg_valid_d  = 1'b0;
            load_done_d  = 1'b0;
            load_error_d = 1'b0;
            off_d        = '0;
        end else if (dl_fall && state_q != IDLE && state_q != DONE && state_q != ERROR) begin
            state_d = ERROR;
        end else if (ioctl_wr && out_valid_q) begin
            // Byte arrived while we were stalling: it is lost.
            state_d = ERROR;
        end else if (ioctl_wr) begin
            case (state_q)
                HDR_ID: begin
                    if (ioctl_dout == ID_END) begin
                        state_d = DONE;
                    end else if (ioctl_dout == ID_CFG) begin
                        is_cfg_d = 1'b1;
                        state_d  = HDR_LEN0;
                    end else if (32'(ioctl_dout) < NUM_REGIONS) begin
                        is_cfg_d  = 1'b0;
                        base_d    = region.base_addr;
                        storage_d = region.storage;
                        state_d   = HDR_LEN0;
                    end else begin
                        state_d = ERROR;
                    end
                end
                HDR_LEN0: begin
                    len_d[23:16] = ioctl_dout;
                    state_d      = HDR_LEN1;
                end
                HDR_LEN1: begin
                    len_d[15:8] = ioctl_dout;
                    state_d     = HDR_LEN2;
                end
                HDR_LEN2: begin
                    len_d = len_full;
                    off_d = '0;
`ifdef LOADER_CHECKSUM_EN
                    csum_d = '0;
`endif
                    if (is_cfg_q) begin
                        state_d = (len_full == 24'd2) ? CFG : ERROR;
                    end else if (len_full > MAX_LEN) begin
                        state_d = ERROR;
                    end else if (len_full == '0) begin
                        state_d = CHUNK_END;
                    end else begin
                        state_d = DATA;
                    end
                end
                DATA: begin
                    lo_d = ioctl_dout;
                    if (off_q[0]) begin
                        out_valid_d   = 1'b1;
                        out_addr_d    = word_addr;
                        out_data_d    = {ioctl_dout, lo_q};
                        out_be_d      = 2'b11;
                        out_storage_d = storage_q;
                    end else if (len_q == 24'd1) begin
                        // Last byte of an odd-length chunk goes out alone.
                        out_valid_d   = 1'b1;
                        out_addr_d    = word_addr;
                        out_data_d    = {8'h00, ioctl_dout};
                        out_be_d      = 2'b01;
                        out_storage_d = storage_q;
                    end
                    off_d = off_q + 24'd1;
                    len_d = len_q - 24'd1;
`ifdef LOADER_CHECKSUM_EN
                    csum_d = csum_q + ioctl_dout;
`endif
                    if (len_q == 24'd1) begin
                        state_d = CHUNK_END;
                    end
                end
                CFG: begin
                    if (!off_q[0]) begin
                        board_cfg_d.game = ioctl_dout;
                    end else begin
                        board_cfg_d.unused = ioctl_dout;
                        cfg_valid_d        = 1'b1;
                        state_d            = CHUNK_END;
                    end
                    off_d = off_q + 24'd1;
`ifdef LOADER_CHECKSUM_EN
                    csum_d = csum_q + ioctl_dout;
`endif
                end
`ifdef LOADER_CHECKSUM_EN
                CSUM: begin
                    // Words already emitted from a bad chunk stay emitted.
                    state_d = (ioctl_dout == csum_q) ? HDR_ID : ERROR;
                end
`endif
                default: ; // IDLE, DONE, ERROR ignore bytes
            endcase
        end

        if (state_d == DONE) begin
            load_done_d = 1'b1;
        end
        if (state_d == ERROR) begin
            load_error_d = 1'b1;
        end
        if (state_d == DONE || state_d == ERROR) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q       <= IDLE;
            dl_q          <= 1'b0;
            is_cfg_q      <= 1'b0;
            len_q         <= '0;
            off_q         <= '0;
            lo_q          <= '0;
            base_q        <= '0;
            storage_q     <= STORAGE_SDR;
            out_valid_q   <= 1'b0;
            out_addr_q    <= '0;
            out_data_q    <= '0;
            out_be_q      <= '0;
            out_storage_q <= STORAGE_SDR;
            board_cfg_q   <= '0;
            cfg_valid_q   <= 1'b0;
            load_done_q   <= 1'b0;
            load_error_q  <= 1'b0;
`ifdef LOADER_CHECKSUM_EN
            csum_q        <= '0;
`endif
        end else begin
            state_q       <= state_d;
            dl_q          <= ioctl_download;
            is_cfg_q      <= is_cfg_d;
            len_q         <= len_d;
            off_q         <= off_d;
            lo_q          <= lo_d;
            base_q        <= base_d;
            storage_q     <= storage_d;
            out_valid_q   <= out_valid_d;
            out_addr_q    <= out_addr_d;
            out_data_q    <= out_data_d;
            out_be_q      <= out_be_d;
            out_storage_q <= out_storage_d;
            board_cfg_q   <= board_cfg_d;
            cfg_valid_q   <= cfg_valid_d;
            load_done_q   <= load_done_d;
            load_error_q  <= load_error_d;
`ifdef LOADER_CHECKSUM_EN
            csum_q        <= csum_d;
`endif
        end
    end

    assign out_valid   = out_valid_q;
    assign ioctl_wait  = out_valid_q;
    assign out_addr    = out_addr_q;
    assign out_data    = out_data_q;
    assign out_be      = out_be_q;
    assign out_storage = out_storage_q;
    assign board_cfg   = board_cfg_q;
    assign cfg_valid   = cfg_valid_q;
    assign load_done   = load_done_q;
    assign load_error  = load_error_q;

endmodule

// File: tb/tb_rom_region_loader.sv
// Bench for rom_region_loader (default build, no trailing checksum bytes).
// Fixed vectors, hand-written stall/abort/reset sequences, then random
// streams with random out_ready checked against a stream-level parser.
module tb_rom_region_loader;
    import rom_region_loader_pkg::*;

    localparam int N_REG = 6;

    typedef struct packed {
        logic [31:0] addr;
        logic [15:0] data;
        logic [1:0]  be;
        logic [3:0]  st;
    } wr_t;
    typedef wr_t        wq_t[$];
    typedef logic [7:0] bq_t[$];

    typedef struct packed {
        logic [127:0] s;     // stream bytes, first byte most significant
        logic [7:0]   n;
        logic [7:0]   nw;
        wr_t          w0;
        wr_t          w1;
        logic         done;
        logic         err;
        logic         cfgv;
        logic [15:0]  cfg;
    } vec_t;

    logic            clk = 1'b0;
    logic            reset_n = 1'b0;
    logic            ioctl_download = 1'b0;
    logic            ioctl_wr = 1'b0;
    logic [7:0]      ioctl_dout = 8'h00;
    logic            ioctl_wait;
    logic            out_valid;
    logic            out_ready = 1'b1;
    logic [31:0]     out_addr;
    logic [15:0]     out_data;
    logic [1:0]      out_be;
    region_storage_t out_storage;
    board_cfg_t      board_cfg;
    logic            cfg_valid;
    logic            load_done;
    logic            load_error;

    int  errors = 0;
    int  checks = 0;
    bit  rnd_ready = 0;
    wq_t cap;
    logic [31:0] ref_base [N_REG];
    logic [3:0]  ref_st   [N_REG];
    vec_t vecs [8];

    rom_region_loader dut (
        .clk(clk), .reset_n(reset_n),
        .ioctl_download(ioctl_download), .ioctl_wr(ioctl_wr),
        .ioctl_dout(ioctl_dout), .ioctl_wait(ioctl_wait),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_addr(out_addr), .out_data(out_data), .out_be(out_be),
        .out_storage(out_storage), .board_cfg(board_cfg), .cfg_valid(cfg_valid),
        .load_done(load_done), .load_error(load_error)
    );

    always #5 clk = ~clk;

    // Inputs only change at posedge+1, so at negedge valid&ready is exactly
    // what the DUT will see at the next rising edge.
    always @(negedge clk) begin
        if (reset_n && out_valid && out_ready)
            cap.push_back('{out_addr, out_data, out_be, out_storage});
    end

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: actual=%h required=%h", nm, act, exp);
        end
    endtask

    task automatic fail(input string nm);
        checks++;
        errors++;
        $display("FAIL %s: bound expired", nm);
    endtask

    function automatic wr_t mkw(input logic [31:0] a, input logic [15:0] d,
                                input logic [1:0] be, input logic [3:0] st);
        return '{a, d, be, st};
    endfunction

    function automatic wr_t cap_at(input int k);
        return (cap.size() > k) ? cap[k] : '1;
    endfunction

    function automatic bq_t bytes_of(input logic [127:0] s, input int n);
        bq_t q;
        for (int k = 0; k < n; k++) q.push_back(s[8*(n-1-k) +: 8]);
        return q;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
        if (rnd_ready) out_ready = 1'($urandom_range(0, 1));
    endtask

    task automatic send_byte(input logic [7:0] b);
        int t = 0;
        while (ioctl_wait && t < 200) begin tick(); t++; end
        if (ioctl_wait) fail("send_wait");
        ioctl_wr = 1'b1;
        ioctl_dout = b;
        tick();
        ioctl_wr = 1'b0;
    endtask

    task automatic send_all(input bq_t q);
        foreach (q[k]) send_byte(q[k]);
    endtask

    task automatic drain();
        int t = 0;
        while (ioctl_wait && t < 200) begin tick(); t++; end
        if (ioctl_wait) fail("drain");
    endtask

    task automatic run_stream(input bq_t q, input bit rnd);
        cap.delete();
        rnd_ready = rnd;
        out_ready = 1'b1;
        ioctl_download = 1'b1;
        tick();
        send_all(q);
        drain();
        rnd_ready = 0;
        out_ready = 1'b1;
        ioctl_download = 1'b0;
        tick();
        tick();
    endtask

    // Stream-level reference: walks the chunk grammar directly. Running out of
    // bytes before the terminator means download fell early, which is an error.
    function automatic void ref_parse(input bq_t s, output wq_t w, output logic done,
                                      output logic err, output logic cfgv,
                                      output logic [15:0] cfg);
        int p = 0;
        int len;
        int id;
        logic [7:0] b, prev;
        w = {}; done = 0; err = 0; cfgv = 0; cfg = '0; prev = '0;
        while (p < s.size()) begin
            id = int'(s[p]); p++;
            if (id == 8'hFF) begin done = 1; return; end
            if (id != 8'h80 && id >= N_REG) begin err = 1; return; end
            if (p + 3 > s.size()) begin err = 1; return; end
            len = int'({s[p], s[p+1], s[p+2]}); p += 3;
            if ((id == 8'h80) ? (len != 2) : (len > 24'h80_0000)) begin err = 1; return; end
            for (int k = 0; k < len; k++) begin
                if (p >= s.size()) begin err = 1; return; end
                b = s[p]; p++;
                if (id == 8'h80) begin
                    if (k == 0) cfg[15:8] = b;
                    else begin cfg[7:0] = b; cfgv = 1; end
                end else if (k % 2 == 1) begin
                    w.push_back(mkw(ref_base[id] + 32'(k - 1), {b, prev}, 2'b11, ref_st[id]));
                end else if (k == len - 1) begin
                    w.push_back(mkw(ref_base[id] + 32'(k), {8'h00, b}, 2'b01, ref_st[id]));
                end else begin
                    prev = b;
                end
            end
        end
        err = 1;
    endfunction

    function automatic bq_t gen_stream();
        bq_t q;
        int nch = $urandom_range(1, 4);
        for (int c = 0; c < nch; c++) begin
            int r = $urandom_range(0, 19);
            int len;
            logic [7:0] id;
            if (r < 12 || r > 16) id = 8'($urandom_range(0, N_REG - 1));
            else if (r < 15) id = 8'h80;
            else if (r == 15) id = 8'($urandom_range(N_REG, 127));
            else id = 8'h00;
            if (id == 8'h80) len = ($urandom_range(0, 9) == 0) ? 3 : 2;
            else len = $urandom_range(0, 7);
            if (r == 16) len = 24'h80_0001;
            q.push_back(id);
            q.push_back(8'(len >> 16));
            q.push_back(8'(len >> 8));
            q.push_back(8'(len));
            if (r != 16)
                for (int k = 0; k < len; k++) q.push_back(8'($urandom));
        end
        if ($urandom_range(0, 3) != 0) begin
            q.push_back(8'hFF);
            if ($urandom_range(0, 1) == 1) q.push_back(8'h00);
        end
        return q;
    endfunction

    initial begin
        bq_t  q;
        wq_t  ew;
        logic edone, eerr, ecfgv;
        logic [15:0] ecfg;

        ref_base = '{32'h0000_0000, 32'h0090_0000, 32'h0000_0000,
                     32'h0020_0000, 32'h0000_0000, 32'h0001_0000};
        ref_st   = '{4'd0, 4'd0, 4'd1, 4'd1, 4'd2, 4'd2};

        vecs[0] = '{128'h00_000004_11223344_FF, 8'd9, 8'd2,
                    mkw(32'h0000_0000, 16'h2211, 2'b11, 4'd0),
                    mkw(32'h0000_0002, 16'h4433, 2'b11, 4'd0), 1'b1, 1'b0, 1'b0, 16'h0000};
        vecs[1] = '{128'h01_000003_AABBCC_FF, 8'd8, 8'd2,
                    mkw(32'h0090_0000, 16'hBBAA, 2'b11, 4'd0),
                    mkw(32'h0090_0002, 16'h00CC, 2'b01, 4'd0), 1'b1, 1'b0, 1'b0, 16'h0000};
        vecs[2] = '{128'h80_000002_0300_FF, 8'd7, 8'd0, '0, '0,
                    1'b1, 1'b0, 1'b1, {GAME_THUNDFOX, 8'h00}};
        vecs[3] = '{128'h07_000001_55_00_000002_1122_FF, 8'd12, 8'd0, '0, '0,
                    1'b0, 1'b1, 1'b0, 16'h0000};
        vecs[4] = '{128'h00_000000_FF, 8'd5, 8'd0, '0, '0, 1'b1, 1'b0, 1'b0, 16'h0000};
        vecs[5] = '{128'h00_800001_FF, 8'd5, 8'd0, '0, '0, 1'b0, 1'b1, 1'b0, 16'h0000};
        vecs[6] = '{128'h80_000003_010203_FF, 8'd8, 8'd0, '0, '0, 1'b0, 1'b1, 1'b0, 16'h0000};
        vecs[7] = '{128'h01_000001_77_00_000002_5566_FF, 8'd12, 8'd2,
                    mkw(32'h0090_0000, 16'h0077, 2'b01, 4'd0),
                    mkw(32'h0000_0000, 16'h6655, 2'b11, 4'd0), 1'b1, 1'b0, 1'b0, 16'h0000};

        // Reset state
        tick(); tick();
        chk("reset_outs", {out_valid, ioctl_wait, out_addr, out_data, out_be, out_storage,
                           cfg_valid, load_done, load_error}, '0);
        chk("reset_cfg", board_cfg, '0);
        reset_n = 1'b1;
        tick();

        // Fixed vectors, out_ready held high
        for (int i = 0; i < 8; i++) begin
            run_stream(bytes_of(vecs[i].s, int'(vecs[i].n)), 0);
            chk($sformatf("v%0d_nwr", i), cap.size(), vecs[i].nw);
            if (vecs[i].nw > 0) chk($sformatf("v%0d_w0", i), cap_at(0), vecs[i].w0);
            if (vecs[i].nw > 1) chk($sformatf("v%0d_w1", i), cap_at(1), vecs[i].w1);
            chk($sformatf("v%0d_flags", i), {load_done, load_error, cfg_valid, board_cfg},
                {vecs[i].done, vecs[i].err, vecs[i].cfgv, vecs[i].cfg});
        end

        // Sink stalled for 10 cycles: the word and the stall stay put
        cap.delete();
        out_ready = 1'b0;
        ioctl_download = 1'b1;
        tick();
        send_all(bytes_of(128'h00_000002_A1B2, 6));
        for (int c = 0; c < 10; c++) begin
            chk($sformatf("stall_hold%0d", c), {out_valid, ioctl_wait, out_addr, out_data, out_be},
                {1'b1, 1'b1, 32'h0000_0000, 16'hB2A1, 2'b11});
            tick();
        end
        out_ready = 1'b1;
        tick(); tick();
        chk("stall_release", {out_valid, ioctl_wait}, 2'b00);
        send_byte(8'hFF);
        tick();
        chk("stall_nwr", cap.size(), 1);
        chk("stall_w", cap_at(0), mkw(32'h0, 16'hB2A1, 2'b11, 4'd0));
        chk("stall_done", {load_done, load_error}, 2'b10);
        ioctl_download = 1'b0;
        tick();

        // Download dropped after two payload bytes, then a clean restart
        cap.delete();
        ioctl_download = 1'b1;
        tick();
        send_all(bytes_of(128'h00_000004_1122, 6));
        drain();
        ioctl_download = 1'b0;
        tick(); tick();
        chk("drop_flags", {load_done, load_error}, 2'b01);
        chk("drop_nwr", cap.size(), 1);
        run_stream(bytes_of(vecs[0].s, 9), 0);
        chk("restart_flags", {load_done, load_error}, 2'b10);
        chk("restart_nwr", cap.size(), 2);
        chk("restart_w1", cap_at(1), vecs[0].w1);

        // Byte strobed while stalled is lost and the loader errors out
        cap.delete();
        out_ready = 1'b0;
        ioctl_download = 1'b1;
        tick();
        send_all(bytes_of(128'h00_000004_1122, 6));
        ioctl_wr = 1'b1;
        ioctl_dout = 8'h33;
        tick();
        ioctl_wr = 1'b0;
        tick();
        chk("lost_state", {load_error, out_valid, ioctl_wait}, 3'b100);
        out_ready = 1'b1;
        send_all(bytes_of(128'h00_000001_99_FF, 6));
        tick();
        chk("lost_ignored", {cap.size() == 0, load_done, out_valid}, 3'b100);
        ioctl_download = 1'b0;
        tick();

        // Download re-rises with a word pending: the word is dropped
        cap.delete();
        out_ready = 1'b0;
        ioctl_download = 1'b1;
        tick();
        send_all(bytes_of(128'h00_000002_1122, 6));
        ioctl_download = 1'b0;
        tick();
        ioctl_download = 1'b1;
        tick(); tick();
        chk("rerise_state", {out_valid, load_done, load_error}, 3'b000);
        out_ready = 1'b1;
        send_byte(8'hFF);
        tick();
        chk("rerise_done", {load_done, load_error}, 2'b10);
        chk("rerise_nwr", cap.size(), 0);
        ioctl_download = 1'b0;
        tick();

        // Reset in the middle of a word
        cap.delete();
        ioctl_download = 1'b1;
        tick();
        send_all(bytes_of(128'h00_000002_11, 5));
        reset_n = 1'b0;
        ioctl_download = 1'b0;
        #1;
        chk("rst_mid_outs", {out_valid, ioctl_wait, out_addr, out_data, out_be, out_storage,
                             cfg_valid, load_done, load_error}, '0);
        tick();
        reset_n = 1'b1;
        tick(); tick();
        chk("rst_mid_nwr", cap.size(), 0);

        // Random streams with random sink backpressure
        for (int it = 0; it < 25; it++) begin
            q = gen_stream();
            ref_parse(q, ew, edone, eerr, ecfgv, ecfg);
            run_stream(q, 1);
            chk($sformatf("rnd%0d_nwr", it), cap.size(), ew.size());
            foreach (ew[k]) chk($sformatf("rnd%0d_w%0d", it, k), cap_at(k), ew[k]);
            chk($sformatf("rnd%0d_flags", it), {load_done, load_error, cfg_valid, board_cfg},
                {edone, eerr, ecfgv, ecfg});
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
